axi4_burst_mst: RTL and testbench

- AXI4 initiator that converts a simple command/stream interface into single-ID INCR bursts on the AXI4 AW/W/B and AR/R channels.
- It drives the AXI4 memory/controller slaves on the interconnect and is the requester counterpart to them.
- It carries one outstanding transaction at a time, write or read, then reports completion on a one-cycle done pulse.

---
 rtl/axi4_burst_mst_pkg.sv | 31 +++
 rtl/axi4_burst_mst.sv | 199 +++++++++++++++++++
 tb/tb_axi4_burst_mst.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_burst_mst_pkg.sv
// ============================================================================
// axi4_burst_mst_pkg : shared widths, FSM encoding and AXI response codes
// Rev 1.0
// ============================================================================
`default_nettype none

package axi4_burst_mst_pkg;

  localparam int unsigned DEF_DATA_W   = 8;
  localparam int unsigned DEF_ADDR_W   = 32;
  localparam int unsigned DEF_MST_ID_W = 5;
  localparam int unsigned DEF_LEN_W    = 8;
  localparam int unsigned DEF_RESP_W   = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_ADDR = 3'd1,
    ST_WR_DATA = 3'd2,
    ST_WR_RESP = 3'd3,
    ST_RD_ADDR = 3'd4,
    ST_RD_DATA = 3'd5
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

`default_nettype wire

// File: rtl/axi4_burst_mst.sv
// ============================================================================
// axi4_burst_mst : command/stream to single-ID AXI4 INCR burst initiator
// Optional ID checking: AXI4_BURST_MST_ID_CHECK_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module axi4_burst_mst
  import axi4_burst_mst_pkg::*;
#(
  parameter int unsigned DATA_W           = DEF_DATA_W,
  parameter int unsigned ADDR_W           = DEF_ADDR_W,
  parameter int unsigned MST_ID_W         = DEF_MST_ID_W,
  parameter int unsigned TRANS_DATA_LEN_W = DEF_LEN_W,
  parameter int unsigned TRANS_RESP_W     = DEF_RESP_W,
  parameter int unsigned MST_ID           = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cmd_wr_i,
  input  logic [ADDR_W-1:0]           cmd_addr_i,
  input  logic [TRANS_DATA_LEN_W-1:0] cmd_len_i,
  input  logic                        cmd_vld_i,
  output logic                        cmd_rdy_o,
  input  logic [DATA_W-1:0]           wr_data_i,
  input  logic                        wr_vld_i,
  output logic                        wr_rdy_o,
  output logic [DATA_W-1:0]           rd_data_o,
  output logic                        rd_last_o,
  output logic                        rd_vld_o,
  input  logic                        rd_rdy_i,
  output logic                        done_vld_o,
  output logic                        done_wr_o,
  output logic [TRANS_RESP_W-1:0]     done_resp_o,
  output logic                        err_o,
  output logic [MST_ID_W-1:0]         s_awid_o,
  output logic [ADDR_W-1:0]           s_awaddr_o,
  output logic [TRANS_DATA_LEN_W-1:0] s_awlen_o,
  output logic                        s_awvalid_o,
  input  logic                        s_awready_i,
  output logic [DATA_W-1:0]           s_wdata_o,
  output logic                        s_wlast_o,
  output logic                        s_wvalid_o,
  input  logic                        s_wready_i,
  input  logic [MST_ID_W-1:0]         s_bid_i,
  input  logic [TRANS_RESP_W-1:0]     s_bresp_i,
  input  logic                        s_bvalid_i,
  output logic                        s_bready_o,
  output logic [MST_ID_W-1:0]         s_arid_o,
  output logic [ADDR_W-1:0]           s_araddr_o,
  output logic [TRANS_DATA_LEN_W-1:0] s_arlen_o,
  output logic                        s_arvalid_o,
  input  logic                        s_arready_i,
  input  logic [MST_ID_W-1:0]         s_rid_i,
  input  logic [DATA_W-1:0]           s_rdata_i,
  input  logic [TRANS_RESP_W-1:0]     s_rresp_i,
  input  logic                        s_rlast_i,
  input  logic                        s_rvalid_i,
  output logic                        s_rready_o
);

  localparam logic [MST_ID_W-1:0]     ID_C     = MST_ID_W'(MST_ID);
  localparam logic [TRANS_RESP_W-1:0] SLVERR_C = TRANS_RESP_W'(RESP_SLVERR);

  state_e                        state_q, state_d;
  logic [ADDR_W-1:0]             addr_q;
  logic [TRANS_DATA_LEN_W-1:0]   len_q, cnt_q;
  logic [TRANS_RESP_W-1:0]       acc_q, done_resp_q;
  logic                          force_q, done_vld_q, done_wr_q, err_q;

  logic                          cmd_hs, wr_hs, rd_hs, b_hs, beat_last;
  logic                          rid_bad, bid_bad, rd_force;
  logic [TRANS_RESP_W-1:0]       rd_resp_max;

  assign beat_last = (cnt_q == len_q);
  assign cmd_hs    = (state_q == ST_IDLE) & ~done_vld_q & cmd_vld_i;
  assign wr_hs     = (state_q == ST_WR_DATA) & wr_vld_i & s_wready_i;
  assign rd_hs     = (state_q == ST_RD_DATA) & s_rvalid_i & rd_rdy_i;
  assign b_hs      = (state_q == ST_WR_RESP) & s_bvalid_i;

`ifdef AXI4_BURST_MST_ID_CHECK_EN
  assign rid_bad = (s_rid_i != ID_C);
  assign bid_bad = (s_bid_i != ID_C);
  assign err_o   = err_q;
`else
  logic unused_ids;
  assign unused_ids = ^{s_rid_i, s_bid_i, err_q};
  assign rid_bad    = 1'b0;
  assign bid_bad    = 1'b0;
  assign err_o      = 1'b0;
`endif

  // A misplaced rlast or foreign ID poisons the whole read burst to SLVERR.
  assign rd_resp_max = (s_rresp_i > acc_q) ? s_rresp_i : acc_q;
  assign rd_force    = force_q | (s_rlast_i != beat_last) | rid_bad;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (cmd_hs) state_d = cmd_wr_i ? ST_WR_ADDR : ST_RD_ADDR;
      ST_WR_ADDR: if (s_awready_i) state_d = ST_WR_DATA;
      ST_WR_DATA: if (wr_hs && beat_last) state_d = ST_WR_RESP;
      ST_WR_RESP: if (s_bvalid_i) state_d = ST_IDLE;
      ST_RD_ADDR: if (s_arready_i) state_d = ST_RD_DATA;
      ST_RD_DATA: if (rd_hs && beat_last) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_rdy_o   = 1'b0;
    s_awvalid_o = 1'b0;
    s_arvalid_o = 1'b0;
    s_wvalid_o  = 1'b0;
    wr_rdy_o    = 1'b0;
    s_wdata_o   = '0;
    s_wlast_o   = 1'b0;
    s_bready_o  = 1'b0;
    rd_vld_o    = 1'b0;
    s_rready_o  = 1'b0;
    rd_data_o   = '0;
    rd_last_o   = 1'b0;
    case (state_q)
      ST_IDLE:    cmd_rdy_o   = rst_n & ~done_vld_q;
      ST_WR_ADDR: s_awvalid_o = 1'b1;
      ST_WR_DATA: begin
        s_wvalid_o = wr_vld_i;
        wr_rdy_o   = s_wready_i;
        s_wdata_o  = wr_data_i;
        s_wlast_o  = beat_last;
      end
      ST_WR_RESP: s_bready_o  = 1'b1;
      ST_RD_ADDR: s_arvalid_o = 1'b1;
      ST_RD_DATA: begin
        rd_vld_o   = s_rvalid_i;
        s_rready_o = rd_rdy_i;
        rd_data_o  = s_rdata_i;
        rd_last_o  = beat_last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      force_q     <= 1'b0;
      done_vld_q  <= 1'b0;
      done_wr_q   <= 1'b0;
      done_resp_q <= '0;
      err_q       <= 1'b0;
    end else begin
      done_vld_q <= 1'b0;
      if (cmd_hs) begin
        addr_q  <= cmd_addr_i;
        len_q   <= cmd_len_i;
        cnt_q   <= '0;
        acc_q   <= '0;
        force_q <= 1'b0;
      end
      if (wr_hs || rd_hs) cnt_q <= cnt_q + 1'b1;
      if (rd_hs) begin
        acc_q   <= rd_resp_max;
        force_q <= rd_force;
      end
      if (rd_hs && beat_last) begin
        done_vld_q  <= 1'b1;
        done_wr_q   <= 1'b0;
        done_resp_q <= rd_force ? SLVERR_C : rd_resp_max;
      end
      if (b_hs) begin
        done_vld_q  <= 1'b1;
        done_wr_q   <= 1'b1;
        done_resp_q <= bid_bad ? SLVERR_C : s_bresp_i;
      end
      if ((rd_hs && rid_bad) || (b_hs && bid_bad)) err_q <= 1'b1;
    end
  end

  assign s_awid_o    = ID_C;
  assign s_arid_o    = ID_C;
  assign s_awaddr_o  = addr_q;
  assign s_araddr_o  = addr_q;
  assign s_awlen_o   = len_q;
  assign s_arlen_o   = len_q;
  assign done_vld_o  = done_vld_q;
  assign done_wr_o   = done_wr_q;
  assign done_resp_o = done_resp_q;

endmodule

`default_nettype wire

// File: tb/tb_axi4_burst_mst.sv
// ============================================================================
// tb_axi4_burst_mst : directed table, random bursts and reset corner for
// axi4_burst_mst.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_axi4_burst_mst;

`ifdef AXI4_BURST_MST_ID_CHECK_EN
  localparam bit ID_CHK = 1'b1;
`else
  localparam bit ID_CHK = 1'b0;
`endif
  localparam int TMO = 2500;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_wr = 1'b0, cmd_vld = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic        cmd_rdy_o;
  logic [7:0]  wr_data = '0;
  logic        wr_vld = 1'b0, wr_rdy_o;
  logic [7:0]  rd_data_o;
  logic        rd_last_o, rd_vld_o;
  logic        rd_rdy = 1'b0;
  logic        done_vld_o, done_wr_o, err_o;
  logic [1:0]  done_resp_o;
  logic [4:0]  s_awid_o, s_arid_o;
  logic [31:0] s_awaddr_o, s_araddr_o;
  logic [7:0]  s_awlen_o, s_arlen_o, s_wdata_o;
  logic        s_awvalid_o, s_arvalid_o, s_wlast_o, s_wvalid_o, s_bready_o, s_rready_o;
  logic        s_awready = 1'b0, s_arready = 1'b0, s_wready = 1'b0;
  logic [4:0]  s_bid = '0, s_rid = '0;
  logic [1:0]  s_bresp = '0, s_rresp = '0;
  logic        s_bvalid = 1'b0, s_rvalid = 1'b0, s_rlast = 1'b0;
  logic [7:0]  s_rdata = '0;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int acc_cyc = 0;
  logic [7:0] tdata  [256];
  logic [1:0] trresp [256];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axi4_burst_mst #(
    .DATA_W(8), .ADDR_W(32), .MST_ID_W(5), .TRANS_DATA_LEN_W(8), .TRANS_RESP_W(2), .MST_ID(0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_wr_i(cmd_wr), .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
    .cmd_vld_i(cmd_vld), .cmd_rdy_o(cmd_rdy_o),
    .wr_data_i(wr_data), .wr_vld_i(wr_vld), .wr_rdy_o(wr_rdy_o),
    .rd_data_o(rd_data_o), .rd_last_o(rd_last_o), .rd_vld_o(rd_vld_o), .rd_rdy_i(rd_rdy),
    .done_vld_o(done_vld_o), .done_wr_o(done_wr_o), .done_resp_o(done_resp_o), .err_o(err_o),
    .s_awid_o(s_awid_o), .s_awaddr_o(s_awaddr_o), .s_awlen_o(s_awlen_o),
    .s_awvalid_o(s_awvalid_o), .s_awready_i(s_awready),
    .s_wdata_o(s_wdata_o), .s_wlast_o(s_wlast_o), .s_wvalid_o(s_wvalid_o), .s_wready_i(s_wready),
    .s_bid_i(s_bid), .s_bresp_i(s_bresp), .s_bvalid_i(s_bvalid), .s_bready_o(s_bready_o),
    .s_arid_o(s_arid_o), .s_araddr_o(s_araddr_o), .s_arlen_o(s_arlen_o),
    .s_arvalid_o(s_arvalid_o), .s_arready_i(s_arready),
    .s_rid_i(s_rid), .s_rdata_i(s_rdata), .s_rresp_i(s_rresp), .s_rlast_i(s_rlast),
    .s_rvalid_i(s_rvalid), .s_rready_o(s_rready_o)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  function automatic bit rnd_rdy(input bit bp);
    return bp ? ($urandom_range(0, 3) != 0) : 1'b1;
  endfunction

  // Reference: what the initiator should report for a completed burst.
  function automatic logic [1:0] model_resp(input bit wr, input int len, input logic [1:0] bresp,
                                            input int bad_last, input logic [4:0] id);
    logic [1:0] e;
    e = 2'd0;
    if (wr) e = bresp;
    else begin
      for (int k = 0; k <= len; k++) if (trresp[k] > e) e = trresp[k];
      if (bad_last >= 0 && bad_last != len) e = 2'd2;
    end
    if (ID_CHK && id != 5'd0) e = 2'd2;
    return e;
  endfunction

  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] bresp, input int bad_last, input logic [4:0] id,
                         input bit bp, input int aw_dly, input logic [1:0] exp_resp,
                         input bit exp_err);
    fork
      begin : f_cmd
        bit acc;
        acc = 1'b0;
        @(negedge clk);
        cmd_vld = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_len = len;
        for (int t = 0; t < TMO && !acc; t++) begin
          #1;
          if (cmd_rdy_o) begin acc = 1'b1; acc_cyc = cyc; end
          @(negedge clk);
        end
        cmd_vld = 1'b0;
        chk("cmd_accept", acc, 1);
      end
      begin : f_ax
        int seen;
        bit hs;
        seen = 0; hs = 1'b0;
        for (int t = 0; t < TMO && !hs; t++) begin
          @(negedge clk);
          s_awready = (seen >= aw_dly);
          s_arready = (seen >= aw_dly);
          #1;
          if (wr ? s_awvalid_o : s_arvalid_o) begin
            if (seen == 0) chk("ax_latency", cyc, acc_cyc + 1);
            chk("ax_addr", wr ? s_awaddr_o : s_araddr_o, addr);
            chk("ax_len", wr ? s_awlen_o : s_arlen_o, len);
            chk("ax_id", wr ? s_awid_o : s_arid_o, 0);
            seen++;
            if (s_awready) hs = 1'b1;
          end
        end
        chk("ax_handshake", hs, 1);
        chk("ax_valid_cycles", seen, aw_dly + 1);
        @(posedge clk); #1;
        s_awready = 1'b0; s_arready = 1'b0;
      end
      begin : f_up
        int i;
        i = 0;
        for (int t = 0; t < TMO && i <= int'(len); t++) begin
          @(negedge clk);
          if (wr) begin
            wr_vld = rnd_rdy(bp); wr_data = tdata[i];
            #1;
            if (wr_vld && wr_rdy_o) i++;
          end else begin
            rd_rdy = rnd_rdy(bp);
            #1;
            if (rd_vld_o && rd_rdy) begin
              chk("rd_data", rd_data_o, tdata[i]);
              chk("rd_last", rd_last_o, i == int'(len));
              chk("cmd_rdy_busy", cmd_rdy_o, 0);
              i++;
            end
          end
        end
        chk("stream_complete", i, int'(len) + 1);
        @(posedge clk); #1;
        wr_vld = 1'b0; rd_rdy = 1'b0;
      end
      begin : f_slv
        int j;
        bit hs;
        j = 0; hs = 1'b0;
        for (int t = 0; t < TMO && j <= int'(len); t++) begin
          @(negedge clk);
          if (wr) begin
            s_wready = rnd_rdy(bp);
            #1;
            if (s_wvalid_o && s_wready) begin
              chk("w_data", s_wdata_o, tdata[j]);
              chk("w_last", s_wlast_o, j == int'(len));
              chk("cmd_rdy_busy", cmd_rdy_o, 0);
              j++;
            end
          end else begin
            s_rvalid = rnd_rdy(bp); s_rdata = tdata[j]; s_rresp = trresp[j]; s_rid = id;
            s_rlast = (bad_last >= 0) ? (j == bad_last) : (j == int'(len));
            #1;
            if (s_rvalid && s_rready_o) j++;
          end
        end
        chk("slave_beats", j, int'(len) + 1);
        if (wr) begin
          @(negedge clk);
          s_wready = 1'b0; s_bvalid = 1'b1; s_bresp = bresp; s_bid = id;
          for (int t = 0; t < TMO && !hs; t++) begin
            #1;
            if (s_bready_o) hs = 1'b1;
            else @(negedge clk);
          end
          chk("b_handshake", hs, 1);
        end
      end
    join
    @(negedge clk);
    s_bvalid = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0; s_wready = 1'b0;
    #1;
    chk("done_vld", done_vld_o, 1);
    chk("done_wr", done_wr_o, wr);
    chk("done_resp", done_resp_o, exp_resp);
    chk("err", err_o, exp_err);
    @(negedge clk); #1;
    chk("done_one_cycle", done_vld_o, 0);
    chk("cmd_rdy_after_done", cmd_rdy_o, 1);
  endtask

  typedef struct {
    bit         wr;
    logic [31:0] addr;
    logic [7:0] len;
    logic [1:0] resp;
    int         bad_last;
    logic [4:0] id;
    bit         bp;
    int         aw_dly;
    logic [1:0] exp_resp;
    bit         exp_err;
  } vec_t;

  vec_t vt [8];

  initial begin
    bit err_exp;
    int bl;
    logic [4:0] id;
    bit wr;
    logic [7:0] len;
    logic [1:0] br;

    vt[0] = '{1'b1, 32'h2300_0000, 8'd3,   2'd0, -1, 5'd0, 1'b0, 0, 2'd0, 1'b0};
    vt[1] = '{1'b0, 32'h2300_0010, 8'd0,   2'd0, -1, 5'd0, 1'b0, 0, 2'd0, 1'b0};
    vt[2] = '{1'b0, 32'h2300_0020, 8'd2,   2'd0,  1, 5'd0, 1'b0, 0, 2'd2, 1'b0};
    vt[3] = '{1'b1, 32'h1000_0100, 8'd7,   2'd1, -1, 5'd0, 1'b1, 5, 2'd1, 1'b0};
    vt[4] = '{1'b0, 32'h4000_0000, 8'd255, 2'd0, -1, 5'd0, 1'b1, 2, 2'd0, 1'b0};
    vt[5] = '{1'b1, 32'h0000_0004, 8'd0,   2'd3, -1, 5'd0, 1'b0, 0, 2'd3, 1'b0};
    vt[6] = '{1'b1, 32'h2300_0040, 8'd1,   2'd0, -1, 5'd5, 1'b0, 0, ID_CHK ? 2'd2 : 2'd0, ID_CHK};
    vt[7] = '{1'b0, 32'h2300_0080, 8'd3,   2'd0, -1, 5'd0, 1'b0, 1, 2'd0, ID_CHK};

    repeat (3) @(negedge clk);
    #1;
    chk("rst_cmd_rdy", cmd_rdy_o, 0);
    chk("rst_valids", {s_awvalid_o, s_arvalid_o, s_wvalid_o, s_bready_o, s_rready_o, rd_vld_o, wr_rdy_o}, 0);
    chk("rst_done", done_vld_o, 0);
    chk("rst_addr", s_awaddr_o, 0);
    chk("rst_err", err_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle_cmd_rdy", cmd_rdy_o, 1);

    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 256; k++) begin
        tdata[k] = 8'($urandom);
        trresp[k] = vt[r].resp;
      end
      if (r == 0) begin tdata[0] = 8'h11; tdata[1] = 8'h22; tdata[2] = 8'h33; tdata[3] = 8'h44; end
      if (r == 1) tdata[0] = 8'hA5;
      run_txn(vt[r].wr, vt[r].addr, vt[r].len, vt[r].resp, vt[r].bad_last, vt[r].id,
              vt[r].bp, vt[r].aw_dly, vt[r].exp_resp, vt[r].exp_err);
    end

    err_exp = ID_CHK;
    for (int n = 0; n < 24; n++) begin
      wr  = 1'($urandom);
      len = 8'($urandom_range(0, 15));
      br  = 2'($urandom);
      for (int k = 0; k < 256; k++) begin
        tdata[k] = 8'($urandom);
        trresp[k] = 2'($urandom);
      end
      bl = ($urandom_range(0, 4) == 0) ? $urandom_range(0, int'(len) + 1) : -1;
      id = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      if (ID_CHK && id != 5'd0) err_exp = 1'b1;
      run_txn(wr, $urandom, len, br, wr ? -1 : bl, id, 1'($urandom), $urandom_range(0, 3),
              model_resp(wr, int'(len), br, wr ? -1 : bl, id), err_exp);
    end

    // Reset while the second of four write beats is on the bus.
    begin
      bit seen;
      seen = 1'b0;
      @(negedge clk);
      cmd_vld = 1'b1; cmd_wr = 1'b1; cmd_addr = 32'h55; cmd_len = 8'd3;
      s_awready = 1'b1; s_wready = 1'b1; wr_vld = 1'b1; wr_data = 8'h11;
      @(negedge clk);
      cmd_vld = 1'b0;
      for (int t = 0; t < 50 && !seen; t++) begin
        #1;
        if (s_wvalid_o && s_wready) seen = 1'b1;
        @(negedge clk);
      end
      chk("rst_first_beat", seen, 1);
      wr_data = 8'h22; rst_n = 1'b0;
      #1;
      chk("rst_second_beat_vld", s_wvalid_o, 1);
      @(negedge clk); #1;
      chk("rst_mid_valids", {s_awvalid_o, s_arvalid_o, s_wvalid_o, s_bready_o, s_rready_o, rd_vld_o, wr_rdy_o}, 0);
      chk("rst_mid_done", done_vld_o, 0);
      chk("rst_mid_err", err_o, 0);
      @(negedge clk);
      rst_n = 1'b1; wr_vld = 1'b0; s_awready = 1'b0; s_wready = 1'b0;
      for (int t = 0; t < 4; t++) begin
        #1;
        chk("rst_no_done", done_vld_o, 0);
        chk("rst_release_cmd_rdy", cmd_rdy_o, 1);
        @(negedge clk);
      end
    end

    for (int k = 0; k < 256; k++) tdata[k] = 8'($urandom);
    run_txn(1'b1, 32'h2300_0100, 8'd2, 2'd0, -1, 5'd0, 1'b0, 0, 2'd0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
